// File: rtl/ram_arbiter_pkg.sv
// ram_arbiter_pkg: shared state encoding and strobe constants for the RAM2 arbiter.
// Rev 1.0
`default_nettype none

package ram_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2,
    ST_HOLD   = 2'd3
  } state_t;

  localparam logic C_STROBE_OFF = 1'b1;
  localparam int   C_WAIT_CNT_W = 4;

endpackage

`default_nettype wire

// File: rtl/ram_arb_priority.sv
// ram_arb_priority: data-first grant selection with a saturating fetch-starvation counter.
// Rev 1.0
`default_nettype none

module ram_arb_priority #(
  parameter int STARVE_LIMIT = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic i_arb_en,
  input  logic i_inst_req,
  input  logic i_data_req,
  output logic o_grant_inst,
  output logic o_grant_data
);

  localparam int            CW      = $clog2(STARVE_LIMIT + 1);
  localparam logic [CW-1:0] C_LIMIT = CW'(STARVE_LIMIT);

  logic [CW-1:0] r_starve_cnt;
  logic          w_force_inst;

  assign w_force_inst = i_inst_req && (r_starve_cnt == C_LIMIT);
  assign o_grant_inst = i_arb_en && i_inst_req && (!i_data_req || w_force_inst);
  assign o_grant_data = i_arb_en && i_data_req && !o_grant_inst;

  // Only data grants that bypass a waiting fetch count against the fetch port.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_starve_cnt <= '0;
    end else if (o_grant_inst) begin
      r_starve_cnt <= '0;
    end else if (o_grant_data && i_inst_req && (r_starve_cnt != C_LIMIT)) begin
      r_starve_cnt <= r_starve_cnt + 1'b1;
    end
  end

endmodule

`default_nettype wire

// File: rtl/ram_arbiter.sv
// ram_arbiter: shares RAM2 between fetch and data ports with a SETUP/ACCESS/HOLD sequence.
// Rev 1.0
`default_nettype none

module ram_arbiter
  import ram_arbiter_pkg::*;
#(
  parameter int ADDR_W       = 16,
  parameter int DATA_W       = 16,
  parameter int WAIT_CYCLES  = 1,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              inst_req_i,
  input  logic [ADDR_W-1:0] inst_addr_i,
  output logic [DATA_W-1:0] inst_data_o,
  output logic              inst_done_o,
  input  logic              data_req_i,
  input  logic              data_we_i,
  input  logic [ADDR_W-1:0] data_addr_i,
  input  logic [DATA_W-1:0] data_wdata_i,
  output logic [DATA_W-1:0] data_rdata_o,
  output logic              data_done_o,
  output logic              pause_o,
  output logic              ram_en_o,
  output logic              ram_oe_o,
  output logic              ram_we_o,
  output logic [ADDR_W-1:0] ram_addr_o,
  output logic [DATA_W-1:0] ram_wdata_o,
  output logic              ram_wdata_oe_o,
  input  logic [DATA_W-1:0] ram_rdata_i
);

  localparam logic [C_WAIT_CNT_W-1:0] C_LAST_CNT = C_WAIT_CNT_W'(WAIT_CYCLES - 1);

  state_t                  r_state;
  logic [C_WAIT_CNT_W-1:0] r_wait_cnt;
  logic                    r_sel_inst;
  logic                    r_we;
  logic [ADDR_W-1:0]       r_addr;
  logic [DATA_W-1:0]       r_wdata;
  logic [DATA_W-1:0]       r_inst_data;
  logic [DATA_W-1:0]       r_data_rdata;
  logic                    r_inst_done;
  logic                    r_data_done;
  logic                    r_en_n;
  logic                    r_oe_n;
  logic                    r_we_n;
  logic                    r_wdata_oe;
  logic                    w_grant_inst;
  logic                    w_grant_data;

  ram_arb_priority #(
    .STARVE_LIMIT(STARVE_LIMIT)
  ) u_priority (
    .clk         (clk),
    .rst         (rst),
    .i_arb_en    (r_state == ST_IDLE),
    .i_inst_req  (inst_req_i),
    .i_data_req  (data_req_i),
    .o_grant_inst(w_grant_inst),
    .o_grant_data(w_grant_data)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= ST_IDLE;
      r_wait_cnt   <= '0;
      r_sel_inst   <= 1'b0;
      r_we         <= 1'b0;
      r_addr       <= '0;
      r_wdata      <= '0;
      r_inst_data  <= '0;
      r_data_rdata <= '0;
      r_inst_done  <= 1'b0;
      r_data_done  <= 1'b0;
      r_en_n       <= C_STROBE_OFF;
      r_oe_n       <= C_STROBE_OFF;
      r_we_n       <= C_STROBE_OFF;
      r_wdata_oe   <= 1'b0;
    end else begin
      r_inst_done <= 1'b0;
      r_data_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_grant_inst || w_grant_data) begin
            r_state    <= ST_SETUP;
            r_sel_inst <= w_grant_inst;
            r_en_n     <= 1'b0;
            if (w_grant_inst) begin
              r_addr     <= inst_addr_i;
              r_we       <= 1'b0;
              r_wdata_oe <= 1'b0;
            end else begin
              r_addr     <= data_addr_i;
              r_we       <= data_we_i;
              r_wdata    <= data_wdata_i;
              r_wdata_oe <= data_we_i;
            end
          end
        end
        ST_SETUP: begin
          r_state    <= ST_ACCESS;
          r_wait_cnt <= '0;
          if (r_we) r_we_n <= 1'b0;
          else      r_oe_n <= 1'b0;
        end
        ST_ACCESS: begin
          // Read data is sampled on the final ACCESS cycle, alongside raising the done pulse.
          if (r_wait_cnt == C_LAST_CNT) begin
            r_state <= ST_HOLD;
            r_we_n  <= C_STROBE_OFF;
            if (r_sel_inst) begin
              r_inst_done <= 1'b1;
              r_inst_data <= ram_rdata_i;
            end else begin
              r_data_done <= 1'b1;
              if (!r_we) r_data_rdata <= ram_rdata_i;
            end
          end else begin
            r_wait_cnt <= r_wait_cnt + 1'b1;
          end
        end
        ST_HOLD: begin
          r_state    <= ST_IDLE;
          r_en_n     <= C_STROBE_OFF;
          r_oe_n     <= C_STROBE_OFF;
          r_wdata_oe <= 1'b0;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign inst_data_o    = r_inst_data;
  assign inst_done_o    = r_inst_done;
  assign data_rdata_o   = r_data_rdata;
  assign data_done_o    = r_data_done;
  assign ram_en_o       = r_en_n;
  assign ram_oe_o       = r_oe_n;
  assign ram_we_o       = r_we_n;
  assign ram_addr_o     = r_addr;
  assign ram_wdata_o    = r_wdata;
  assign ram_wdata_oe_o = r_wdata_oe;
  assign pause_o        = (inst_req_i & ~r_inst_done) | (data_req_i & ~r_data_done);

endmodule

`default_nettype wire

// File: tb/tb_ram_arbiter.sv
// tb_ram_arbiter: directed checks of sequencing, arbitration, starvation and reset.
// Rev 1.0
`default_nettype none

module tb_ram_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  int          n_err = 0;
  int          n_checks = 0;

  // Instance A: WAIT_CYCLES = 1
  logic        inst_req = 0, data_req = 0, data_we = 0;
  logic [15:0] inst_addr = 0, data_addr = 0, data_wdata = 0, rd_a = 0;
  logic [15:0] inst_data, data_rdata, ram_addr, ram_wdata;
  logic        inst_done, data_done, pause, en, oe, we, wdata_oe;

  // Instance B: WAIT_CYCLES = 3
  logic        b_inst_req = 0, b_data_req = 0, b_data_we = 0;
  logic [15:0] b_inst_addr = 0, b_data_addr = 0, b_data_wdata = 0, rd_b = 0;
  logic [15:0] b_inst_data, b_data_rdata, b_ram_addr, b_ram_wdata;
  logic        b_inst_done, b_data_done, b_pause, b_en, b_oe, b_we, b_wdata_oe;

  always #5 clk = ~clk;

  ram_arbiter #(.ADDR_W(16), .DATA_W(16), .WAIT_CYCLES(1), .STARVE_LIMIT(4)) u_dut (
    .clk(clk), .rst(rst),
    .inst_req_i(inst_req), .inst_addr_i(inst_addr), .inst_data_o(inst_data), .inst_done_o(inst_done),
    .data_req_i(data_req), .data_we_i(data_we), .data_addr_i(data_addr), .data_wdata_i(data_wdata),
    .data_rdata_o(data_rdata), .data_done_o(data_done), .pause_o(pause),
    .ram_en_o(en), .ram_oe_o(oe), .ram_we_o(we), .ram_addr_o(ram_addr),
    .ram_wdata_o(ram_wdata), .ram_wdata_oe_o(wdata_oe), .ram_rdata_i(rd_a)
  );

  ram_arbiter #(.ADDR_W(16), .DATA_W(16), .WAIT_CYCLES(3), .STARVE_LIMIT(4)) u_dut_w3 (
    .clk(clk), .rst(rst),
    .inst_req_i(b_inst_req), .inst_addr_i(b_inst_addr), .inst_data_o(b_inst_data), .inst_done_o(b_inst_done),
    .data_req_i(b_data_req), .data_we_i(b_data_we), .data_addr_i(b_data_addr), .data_wdata_i(b_data_wdata),
    .data_rdata_o(b_data_rdata), .data_done_o(b_data_done), .pause_o(b_pause),
    .ram_en_o(b_en), .ram_oe_o(b_oe), .ram_we_o(b_we), .ram_addr_o(b_ram_addr),
    .ram_wdata_o(b_ram_wdata), .ram_wdata_oe_o(b_wdata_oe), .ram_rdata_i(rd_b)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Moves to 2 time units after the next rising edge; drives happen here, checks after a further #1.
  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    // Reset state
    cyc(); cyc(); #1;
    chk("rst_en", en, 1); chk("rst_oe", oe, 1); chk("rst_we", we, 1);
    chk("rst_wdata_oe", wdata_oe, 0); chk("rst_addr", ram_addr, 0);
    chk("rst_inst_done", inst_done, 0); chk("rst_data_done", data_done, 0);
    chk("rst_inst_data", inst_data, 0); chk("rst_data_rdata", data_rdata, 0);
    rst = 0;
    cyc();

    // Fetch read 0x0040 -> 0x1234
    cyc(); inst_req = 1; inst_addr = 16'h0040; rd_a = 16'h1234; #1;
    chk("t1_c0_pause", pause, 1); chk("t1_c0_en", en, 1);
    cyc(); #1;
    chk("t1_c1_en", en, 0); chk("t1_c1_oe", oe, 1); chk("t1_c1_addr", ram_addr, 16'h0040);
    cyc(); #1;
    chk("t1_c2_oe", oe, 0); chk("t1_c2_we", we, 1); chk("t1_c2_done", inst_done, 0);
    cyc(); #1;
    chk("t1_c3_done", inst_done, 1); chk("t1_c3_data", inst_data, 16'h1234);
    chk("t1_c3_pause", pause, 0); chk("t1_c3_oe", oe, 0); chk("t1_c3_en", en, 0);
    cyc(); inst_req = 0; #1;
    chk("t1_c4_en", en, 1); chk("t1_c4_oe", oe, 1); chk("t1_c4_done", inst_done, 0);

    // Data write 0xBEEF -> 0x8001
    cyc(); data_req = 1; data_we = 1; data_addr = 16'h8001; data_wdata = 16'hBEEF; #1;
    chk("t2_c0_pause", pause, 1); chk("t2_c0_wdata_oe", wdata_oe, 0);
    cyc(); #1;
    chk("t2_c1_wdata_oe", wdata_oe, 1); chk("t2_c1_we", we, 1); chk("t2_c1_oe", oe, 1);
    chk("t2_c1_addr", ram_addr, 16'h8001); chk("t2_c1_wdata", ram_wdata, 16'hBEEF);
    cyc(); #1;
    chk("t2_c2_we", we, 0); chk("t2_c2_oe", oe, 1); chk("t2_c2_wdata_oe", wdata_oe, 1);
    cyc(); #1;
    chk("t2_c3_we", we, 1); chk("t2_c3_oe", oe, 1); chk("t2_c3_wdata_oe", wdata_oe, 1);
    chk("t2_c3_done", data_done, 1); chk("t2_c3_inst_done", inst_done, 0); chk("t2_c3_pause", pause, 0);
    cyc(); data_req = 0; data_we = 0; #1;
    chk("t2_c4_wdata_oe", wdata_oe, 0); chk("t2_c4_done", data_done, 0);

    // Simultaneous requests: data first, then fetch
    cyc(); data_req = 1; data_addr = 16'h0100; inst_req = 1; inst_addr = 16'h0200; rd_a = 16'hAAAA; #1;
    cyc(); #1;
    chk("t3_c1_addr", ram_addr, 16'h0100);
    cyc(); cyc(); #1;
    chk("t3_c3_data_done", data_done, 1); chk("t3_c3_inst_done", inst_done, 0);
    chk("t3_c3_rdata", data_rdata, 16'hAAAA); chk("t3_c3_pause", pause, 1);
    cyc(); data_req = 0; rd_a = 16'h5555; #1;
    chk("t3_c4_pause", pause, 1);
    cyc(); #1;
    chk("t3_c5_addr", ram_addr, 16'h0200);
    cyc(); cyc(); #1;
    chk("t3_c7_inst_done", inst_done, 1); chk("t3_c7_inst_data", inst_data, 16'h5555);
    chk("t3_c7_pause", pause, 0); chk("t3_c7_rdata_held", data_rdata, 16'hAAAA);
    cyc(); inst_req = 0;

    // Starvation: pattern D D D D I repeated while both requests stay high
    cyc(); data_req = 1; data_we = 0; data_addr = 16'h0300; inst_req = 1; inst_addr = 16'h0400; rd_a = 16'h7777;
    for (int k = 0; k < 10; k++) begin
      cyc(); cyc(); cyc(); #1;
      chk($sformatf("t4_g%0d_data_done", k), data_done, (k % 5 != 4) ? 1 : 0);
      chk($sformatf("t4_g%0d_inst_done", k), inst_done, (k % 5 == 4) ? 1 : 0);
      cyc();
    end
    data_req = 0; inst_req = 0;
    cyc(); #1;
    chk("t4_idle_en", en, 1);

    // Reset during a write ACCESS, request held so it restarts
    cyc(); data_req = 1; data_we = 1; data_addr = 16'h0500; data_wdata = 16'hCAFE;
    cyc();
    cyc(); #1;
    chk("t5_c2_we", we, 0);
    rst = 1;
    cyc(); #1;
    chk("t5_c3_en", en, 1); chk("t5_c3_oe", oe, 1); chk("t5_c3_we", we, 1);
    chk("t5_c3_wdata_oe", wdata_oe, 0); chk("t5_c3_done", data_done, 0); chk("t5_c3_addr", ram_addr, 0);
    rst = 0;
    cyc(); #1;
    chk("t5_c4_en", en, 0); chk("t5_c4_wdata_oe", wdata_oe, 1); chk("t5_c4_done", data_done, 0);
    cyc(); #1;
    chk("t5_c5_we", we, 0);
    cyc(); #1;
    chk("t5_c6_done", data_done, 1); chk("t5_c6_wdata", ram_wdata, 16'hCAFE);
    cyc(); data_req = 0; data_we = 0;

    // WAIT_CYCLES = 3 read: data sampled on third ACCESS cycle
    cyc(); b_data_req = 1; b_data_we = 0; b_data_addr = 16'h0600;
    cyc(); #1;
    chk("t6_c1_oe", b_oe, 1); chk("t6_c1_en", b_en, 0);
    cyc(); rd_b = 16'h1111; #1;
    chk("t6_c2_oe", b_oe, 0);
    cyc(); rd_b = 16'h2222; #1;
    chk("t6_c3_done", b_data_done, 0);
    cyc(); rd_b = 16'h3333; #1;
    chk("t6_c4_done", b_data_done, 0); chk("t6_c4_oe", b_oe, 0);
    cyc(); rd_b = 16'h4444; #1;
    chk("t6_c5_done", b_data_done, 1); chk("t6_c5_rdata", b_data_rdata, 16'h3333); chk("t6_c5_pause", b_pause, 0);
    cyc(); b_data_req = 0; #1;
    chk("t6_c6_done", b_data_done, 0); chk("t6_c6_oe", b_oe, 1);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/ram_arbiter.md
Name: ram_arbiter

Overview:
- Sequences and shares the single off-chip RAM2 SRAM between two requesters: the instruction-fetch port and the data (MEM-stage) port.
- Runs one SRAM access at a time through a fixed SETUP/ACCESS/HOLD phase sequence and drives the active-low SRAM strobes.
- Returns read data and a one-cycle done pulse to the winning requester, and raises a pipeline pause while any request is outstanding.
- Sits between mem_control and ram_control; it replaces ad-hoc combinational sharing of RAM2.

Parameters:
- ADDR_W, 16, address width (matches `MemAddrBus).
- DATA_W, 16, data width (matches `MemBus).
- WAIT_CYCLES, 1, number of ACCESS-phase cycles (1..15).
- STARVE_LIMIT, 4, consecutive data-port grants allowed while fetch is pending before fetch is forced through.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- inst_req_i  in  1  fetch request; held until inst_done_o
- inst_addr_i  in  ADDR_W  fetch address
- inst_data_o  out  DATA_W  fetched word, registered
- inst_done_o  out  1  one-cycle fetch completion pulse
- data_req_i  in  1  data request; held until data_done_o
- data_we_i  in  1  1 = write, 0 = read
- data_addr_i  in  ADDR_W  data address
- data_wdata_i  in  DATA_W  write data
- data_rdata_o  out  DATA_W  read word, registered
- data_done_o  out  1  one-cycle data completion pulse
- pause_o  out  1  pipeline stall request
- ram_en_o, ram_oe_o, ram_we_o  out  1 each  SRAM strobes, active-low
- ram_addr_o  out  ADDR_W  SRAM address, registered
- ram_wdata_o  out  DATA_W  SRAM write data
- ram_wdata_oe_o  out  1  tristate drive enable for ram_control
- ram_rdata_i  in  DATA_W  SRAM read data

Behaviour:
- Interface: one clock, clk. rst is synchronous and active-high.
- Reset values: state IDLE; ram_en_o/ram_oe_o/ram_we_o = 1; ram_wdata_oe_o = 0; addr and data outputs 0; both done pulses 0; starvation counter 0.
- Reset mid-operation aborts the transaction immediately. No done pulse is issued.
- States:
  - IDLE: arbitrate among pending requests.
  - SETUP: 1 cycle.
  - ACCESS: WAIT_CYCLES cycles, counted with a 4-bit counter.
  - HOLD: 1 cycle.
- Transitions:
  - IDLE→SETUP when any request is pending.
  - SETUP→ACCESS.
  - ACCESS→HOLD when the counter reaches WAIT_CYCLES-1.
  - HOLD→IDLE unconditionally. Arbitration never happens in HOLD, because the finishing requester's req is still high in that cycle.
- Arbitration (IDLE only):
  - Data port has priority.
  - Exception: fetch wins if it is pending and the starvation counter equals STARVE_LIMIT.
  - The counter increments on each data grant made while fetch is pending, resets on every fetch grant, and saturates.
- Grant latches addr, we and wdata into registers. Requester inputs are ignored after that. Fetch is always a read.
- Strobes:
  - ram_en_o = 0 during SETUP, ACCESS and HOLD.
  - Read: ram_oe_o = 0 during ACCESS and HOLD.
  - Write: ram_we_o = 0 during ACCESS only. ram_wdata_oe_o = 1 during SETUP, ACCESS and HOLD.
  - ram_oe_o and ram_we_o are never both 0.
- Read data is captured from ram_rdata_i on the last ACCESS cycle into the granted port's rdata register. The value holds until that port's next read completes.
- done: pulses for exactly the HOLD cycle, on the granted port only. Writes also pulse data_done_o.
- Latency from a request sampled in IDLE at cycle 0: SETUP at 1, ACCESS at 2..1+W, HOLD/done at 2+W. With W=1, done is at cycle 3 and throughput is 4 cycles per access.
- Request deasserted mid-transaction: the access still completes and done still pulses.
- pause_o (combinational) = (inst_req_i & ~inst_done_o) | (data_req_i & ~data_done_o).
- Addresses pass through unmodified; no width arithmetic and no wrap-around handling.

Decomposition:
- defines.v: state encodings (IDLE/SETUP/ACCESS/HOLD), `RamStrobeOff = 1'b1, and reuse of `MemAddrBus/`MemBus.
- One sub-module, ram_arb_priority: grant selection plus the saturating starvation counter. Outputs grant_inst and grant_data, one-hot or none.

Test Plan:
- Fetch read, addr 0x0040, SRAM returns 0x1234, W=1 -> strobes low at cycles 1–3, oe low at cycles 2–3, inst_done_o at cycle 3, inst_data_o = 0x1234, pause_o falls at cycle 3.
- Data write 0xBEEF to 0x8001 -> we low only in the ACCESS cycle, ram_wdata_oe_o high for 3 cycles, data_done_o at cycle 3, ram_oe_o stays 1 throughout.
- Both requests in the same IDLE cycle -> data served first (done at cycle 3), fetch next (done at cycle 7), pause_o high until cycle 7.
- Data request held continuously with fetch pending, STARVE_LIMIT=4 -> 4 data grants, 5th grant goes to fetch, counter returns to 0.
- W=3, read -> ACCESS lasts 3 cycles, read data sampled on the 3rd, done at cycle 5.
- rst asserted during ACCESS -> next cycle all strobes 1, ram_wdata_oe_o 0, no done pulse, state IDLE. A held request restarts afterwards.
